// File: rtl/dsp_acc_control_if.sv
// Handshake bundle between the word source and the DSP accumulator controller.
// Carries the word strobes and channel mask in, and the DSP mode commands and event status out.
interface dsp_acc_control_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic             DV;
    logic             EV;
    logic [NCH-1:0]   CH_EN;
    logic [NCH-1:0]   MODECP;
    logic [NCH-1:0]   MODE0;
    logic             DVout;
    logic [NCH-1:0]   RESULT_VALID;
    logic [CNT_W-1:0] WORD_CNT;
    logic             OVF;
    logic [1:0]       state_out;

    modport master (
        output DV, EV, CH_EN,
        input  MODECP, MODE0, DVout, RESULT_VALID, WORD_CNT, OVF, state_out
    );

    modport slave (
        input  DV, EV, CH_EN,
        output MODECP, MODE0, DVout, RESULT_VALID, WORD_CNT, OVF, state_out
    );
endinterface

// File: rtl/dsp_acc_control.sv
// Sequences load/accumulate commands for NCH DSP accumulators over word events, and
// flags the cycle each channel's P register holds the completed event sum.
module dsp_acc_control #(
    parameter int NCH   = 4,
    parameter int LAT   = 3,
    parameter int CNT_W = 8,
    parameter int MAXW  = 200
) (
    input  logic             CLOCK,
    input  logic             RESET,
    dsp_acc_control_if.slave bus
);
    localparam int FL_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACC     = 2'b01,
        FLUSH   = 2'b10,
        DISCARD = 2'b11
    } state_t;

    state_t           state_q, state_nx;
    logic [NCH-1:0]   mask_q, mask_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             ovf_q, ovf_nx;
    logic [FL_W-1:0]  fl_q, fl_nx;
    logic [NCH-1:0]   modecp_nx, mode0_nx, last_nx;

    logic [NCH-1:0]   modecp_p1, mode0_p1;
    logic [NCH-1:0]   rv_pipe [LAT];
    logic [NCH-1:0]   rv_p;
    logic [LAT:0]     dv_pipe;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            fl_q    <= '0;
        end else begin
            state_q <= state_nx;
            mask_q  <= mask_nx;
            cnt_q   <= cnt_nx;
            ovf_q   <= ovf_nx;
            fl_q    <= fl_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        mask_nx   = mask_q;
        cnt_nx    = cnt_q;
        ovf_nx    = ovf_q;
        fl_nx     = fl_q;
        modecp_nx = '0;
        mode0_nx  = '0;
        last_nx   = '0;
        case (state_q)
            IDLE, FLUSH: begin
                if (bus.DV) begin
                    // First word of an event: the mask seen now is held until the event ends.
                    mask_nx   = bus.CH_EN;
                    modecp_nx = bus.CH_EN;
                    cnt_nx    = CNT_W'(1);
                    ovf_nx    = 1'b0;
                    fl_nx     = '0;
                    if (bus.EV) begin
                        last_nx  = bus.CH_EN;
                        state_nx = FLUSH;
                    end else begin
                        state_nx = ACC;
                    end
                end else if (state_q == FLUSH) begin
                    if (fl_q == FL_W'(LAT - 1))
                        state_nx = IDLE;
                    else
                        fl_nx = fl_q + 1'b1;
                end
            end
            ACC: begin
                if (bus.DV) begin
                    // A word beyond MAXW is dropped and the rest of the event is discarded.
                    if (cnt_q >= CNT_W'(MAXW)) begin
                        ovf_nx   = 1'b1;
                        state_nx = bus.EV ? IDLE : DISCARD;
                    end else begin
                        mode0_nx = mask_q;
                        cnt_nx   = cnt_q + 1'b1;
                        if (bus.EV) begin
                            last_nx  = mask_q;
                            fl_nx    = '0;
                            state_nx = FLUSH;
                        end
                    end
                end
            end
            DISCARD: begin
                if (bus.DV && bus.EV)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p1: registered DSP mode commands; result masks ride an LAT-deep pipe behind them.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            modecp_p1 <= '0;
            mode0_p1  <= '0;
            rv_p      <= '0;
            dv_pipe   <= '0;
            for (int i = 0; i < LAT; i++)
                rv_pipe[i] <= '0;
        end else begin
            modecp_p1  <= modecp_nx;
            mode0_p1   <= mode0_nx;
            rv_pipe[0] <= last_nx;
            for (int i = 1; i < LAT; i++)
                rv_pipe[i] <= rv_pipe[i-1];
            rv_p    <= rv_pipe[LAT-1];
            dv_pipe <= {dv_pipe[LAT-1:0], bus.DV};
        end
    end

    assign bus.MODECP       = modecp_p1;
    assign bus.MODE0        = mode0_p1;
    assign bus.RESULT_VALID = rv_p;
    assign bus.DVout        = dv_pipe[LAT];
    assign bus.WORD_CNT     = cnt_q;
    assign bus.OVF          = ovf_q;
    assign bus.state_out    = state_q;
endmodule

// File: tb/tb_dsp_acc_control.sv
// Directed bench for dsp_acc_control with NCH=4, LAT=3, MAXW=8.
// Each row drives one cycle of inputs; the expected row is the registered view one edge later.
module tb_dsp_acc_control;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dsp_acc_control_if #(.NCH(4), .CNT_W(8)) bus ();

    dsp_acc_control #(.NCH(4), .LAT(3), .CNT_W(8), .MAXW(8)) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rst_n;
        logic       dv;
        logic       ev;
        logic [3:0] ch;
    } stim_t;

    typedef struct packed {
        logic [3:0] cp;
        logic [3:0] m0;
        logic [3:0] rv;
        logic       dvo;
        logic [1:0] st;
        logic [7:0] wc;
        logic       ovf;
    } obs_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t sv(int r, int dv, int ev, int ch);
        stim_t s;
        s.rst_n = 1'(r);
        s.dv    = 1'(dv);
        s.ev    = 1'(ev);
        s.ch    = 4'(ch);
        return s;
    endfunction

    function automatic obs_t mk(int cp, int m0, int rv, int dvo, int st, int wc, int ovf);
        obs_t o;
        o.cp  = 4'(cp);
        o.m0  = 4'(m0);
        o.rv  = 4'(rv);
        o.dvo = 1'(dvo);
        o.st  = 2'(st);
        o.wc  = 8'(wc);
        o.ovf = 1'(ovf);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cp  = bus.MODECP;
        o.m0  = bus.MODE0;
        o.rv  = bus.RESULT_VALID;
        o.dvo = bus.DVout;
        o.st  = bus.state_out;
        o.wc  = bus.WORD_CNT;
        o.ovf = bus.OVF;
        return o;
    endfunction

    task automatic drive(stim_t s);
        rst_n     = s.rst_n;
        bus.DV    = s.dv;
        bus.EV    = s.ev;
        bus.CH_EN = s.ch;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        drive(sv(0, 1, 0, 'hF));
        for (int k = 0; k < 3; k++) begin
            if (k == 2) drive(sv(1, 0, 0, 'h0));
            tick();
            got = sample();
            vectors++;
            if (got !== mk(0, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h want %h", k, got, mk(0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_basic();
        stim_t s [7];
        obs_t  e [7];
        obs_t  got;
        s[0] = sv(1, 1, 0, 'hF); e[0] = mk('hF, 0, 0, 0, 1, 1, 0);
        s[1] = sv(1, 1, 0, 'h0); e[1] = mk(0, 'hF, 0, 0, 1, 2, 0);
        s[2] = sv(1, 1, 1, 'h3); e[2] = mk(0, 'hF, 0, 0, 2, 3, 0);
        s[3] = sv(1, 0, 0, 'h0); e[3] = mk(0, 0, 0, 1, 2, 3, 0);
        s[4] = sv(1, 0, 0, 'h0); e[4] = mk(0, 0, 0, 1, 2, 3, 0);
        s[5] = sv(1, 0, 0, 'h0); e[5] = mk(0, 0, 'hF, 1, 0, 3, 0);
        s[6] = sv(1, 0, 0, 'h0); e[6] = mk(0, 0, 0, 0, 0, 3, 0);
        for (int k = 0; k < 7; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL basic t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    task automatic test_single_word();
        stim_t s [5];
        obs_t  e [5];
        obs_t  got;
        s[0] = sv(1, 1, 1, 'h5); e[0] = mk('h5, 0, 0, 0, 2, 1, 0);
        s[1] = sv(1, 0, 0, 'hF); e[1] = mk(0, 0, 0, 0, 2, 1, 0);
        s[2] = sv(1, 0, 0, 'h0); e[2] = mk(0, 0, 0, 0, 2, 1, 0);
        s[3] = sv(1, 0, 0, 'h0); e[3] = mk(0, 0, 'h5, 1, 0, 1, 0);
        s[4] = sv(1, 0, 0, 'h0); e[4] = mk(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL single t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s [8];
        obs_t  e [8];
        obs_t  got;
        s[0] = sv(1, 1, 0, 'hF); e[0] = mk('hF, 0, 0, 0, 1, 1, 0);
        s[1] = sv(1, 1, 1, 'h0); e[1] = mk(0, 'hF, 0, 0, 2, 2, 0);
        s[2] = sv(1, 1, 0, 'h3); e[2] = mk('h3, 0, 0, 0, 1, 1, 0);
        s[3] = sv(1, 1, 1, 'hF); e[3] = mk(0, 'h3, 0, 1, 2, 2, 0);
        s[4] = sv(1, 0, 0, 'h0); e[4] = mk(0, 0, 'hF, 1, 2, 2, 0);
        s[5] = sv(1, 0, 0, 'h0); e[5] = mk(0, 0, 0, 1, 2, 2, 0);
        s[6] = sv(1, 0, 0, 'h0); e[6] = mk(0, 0, 'h3, 1, 0, 2, 0);
        s[7] = sv(1, 0, 0, 'h0); e[7] = mk(0, 0, 0, 0, 0, 2, 0);
        for (int k = 0; k < 8; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL back_to_back t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t s [15];
        obs_t  e [15];
        obs_t  got;
        s[0]  = sv(1, 1, 0, 'hF); e[0]  = mk('hF, 0, 0, 0, 1, 1, 0);
        s[1]  = sv(1, 1, 0, 'hF); e[1]  = mk(0, 'hF, 0, 0, 1, 2, 0);
        s[2]  = sv(1, 1, 0, 'hF); e[2]  = mk(0, 'hF, 0, 0, 1, 3, 0);
        s[3]  = sv(1, 1, 0, 'hF); e[3]  = mk(0, 'hF, 0, 1, 1, 4, 0);
        s[4]  = sv(1, 1, 0, 'hF); e[4]  = mk(0, 'hF, 0, 1, 1, 5, 0);
        s[5]  = sv(1, 1, 0, 'hF); e[5]  = mk(0, 'hF, 0, 1, 1, 6, 0);
        s[6]  = sv(1, 1, 0, 'hF); e[6]  = mk(0, 'hF, 0, 1, 1, 7, 0);
        s[7]  = sv(1, 1, 0, 'hF); e[7]  = mk(0, 'hF, 0, 1, 1, 8, 0);
        s[8]  = sv(1, 1, 0, 'hF); e[8]  = mk(0, 0, 0, 1, 3, 8, 1);
        s[9]  = sv(1, 1, 0, 'hF); e[9]  = mk(0, 0, 0, 1, 3, 8, 1);
        s[10] = sv(1, 1, 1, 'hF); e[10] = mk(0, 0, 0, 1, 0, 8, 1);
        s[11] = sv(1, 0, 0, 'h0); e[11] = mk(0, 0, 0, 1, 0, 8, 1);
        s[12] = sv(1, 0, 0, 'h0); e[12] = mk(0, 0, 0, 1, 0, 8, 1);
        s[13] = sv(1, 0, 0, 'h0); e[13] = mk(0, 0, 0, 1, 0, 8, 1);
        s[14] = sv(1, 0, 0, 'h0); e[14] = mk(0, 0, 0, 0, 0, 8, 1);
        for (int k = 0; k < 15; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL overflow t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    task automatic test_maxw_last();
        stim_t s [12];
        obs_t  e [12];
        obs_t  got;
        s[0]  = sv(1, 1, 0, 'hA); e[0]  = mk('hA, 0, 0, 0, 1, 1, 0);
        s[1]  = sv(1, 1, 0, 'h0); e[1]  = mk(0, 'hA, 0, 0, 1, 2, 0);
        s[2]  = sv(1, 1, 0, 'h0); e[2]  = mk(0, 'hA, 0, 0, 1, 3, 0);
        s[3]  = sv(1, 1, 0, 'h0); e[3]  = mk(0, 'hA, 0, 1, 1, 4, 0);
        s[4]  = sv(1, 1, 0, 'h0); e[4]  = mk(0, 'hA, 0, 1, 1, 5, 0);
        s[5]  = sv(1, 1, 0, 'h0); e[5]  = mk(0, 'hA, 0, 1, 1, 6, 0);
        s[6]  = sv(1, 1, 0, 'h0); e[6]  = mk(0, 'hA, 0, 1, 1, 7, 0);
        s[7]  = sv(1, 1, 1, 'h0); e[7]  = mk(0, 'hA, 0, 1, 2, 8, 0);
        s[8]  = sv(1, 0, 0, 'h0); e[8]  = mk(0, 0, 0, 1, 2, 8, 0);
        s[9]  = sv(1, 0, 0, 'h0); e[9]  = mk(0, 0, 0, 1, 2, 8, 0);
        s[10] = sv(1, 0, 0, 'h0); e[10] = mk(0, 0, 'hA, 1, 0, 8, 0);
        s[11] = sv(1, 0, 0, 'h0); e[11] = mk(0, 0, 0, 0, 0, 8, 0);
        for (int k = 0; k < 12; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL maxw_last t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    task automatic test_reset_mid_event();
        stim_t s [11];
        obs_t  e [11];
        obs_t  got;
        s[0] = sv(1, 1, 0, 'hF); e[0] = mk('hF, 0, 0, 0, 1, 1, 0);
        s[1] = sv(1, 1, 0, 'hF); e[1] = mk(0, 'hF, 0, 0, 1, 2, 0);
        s[2] = sv(0, 0, 0, 'h0); e[2] = mk(0, 0, 0, 0, 0, 0, 0);
        for (int k = 3; k < 10; k++) begin
            s[k] = sv(1, 0, 0, 'h0);
            e[k] = mk(0, 0, 0, 0, 0, 0, 0);
        end
        s[10] = sv(1, 1, 1, 'h6); e[10] = mk('h6, 0, 0, 0, 2, 1, 0);
        for (int k = 0; k < 11; k++) begin
            drive(s[k]);
            tick();
            got = sample();
            vectors++;
            if (got !== e[k]) begin
                miscompares++;
                $display("FAIL reset_mid t0+%0d: got %h want %h", k + 1, got, e[k]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.DV      = 1'b0;
        bus.EV      = 1'b0;
        bus.CH_EN   = '0;
        test_reset();
        test_basic();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_maxw_last();
        test_reset_mid_event();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dsp_acc_control.md
DSP_ACC_CONTROL -- requirements
Module: dsp_acc_control

Interface
REQ-001 Parameter NCH, default 4: number of DSP accumulator channels controlled.
REQ-002 Parameter LAT, default 3: DSP pipeline latency, in cycles, from the registered mode to the valid P output; legal range 1..8.
REQ-003 Parameter CNT_W, default 8: width of the word counter.
REQ-004 Parameter MAXW, default 200: maximum number of words per event; legal range 1..2^CNT_W-1.
REQ-005 The block SHALL use one clock. CLOCK  in  1  system clock, all logic on rising edge.
REQ-006 The reset is synchronous and active-low. RESET  in  1  synchronous reset, active-low.
REQ-007 DV  in  1  input data word valid.
REQ-008 EV  in  1  end of event; marks the current DV word as the last word; ignored when DV=0.
REQ-009 CH_EN  in  NCH  channel enable mask.
REQ-010 MODECP  out  NCH  per-channel load command (P=A*B).
REQ-011 MODE0  out  NCH  per-channel accumulate command (P=P+A*B).
REQ-012 DVout  out  1  DV delayed to align with the DSP output.
REQ-013 RESULT_VALID  out  NCH  per-channel one-cycle pulse when P holds the final event sum.
REQ-014 WORD_CNT  out  CNT_W  word count of the current or most recent event.
REQ-015 OVF  out  1  event overflow flag.
REQ-016 state_out  out  2  FSM state encoding.

Function
REQ-017 The FSM SHALL have four states: IDLE=00, ACC=01, FLUSH=10, DISCARD=11, and state_out SHALL equal the current state.
REQ-018 MODECP, MODE0, DVout and RESULT_VALID SHALL all be registered outputs.
REQ-019 A word at input cycle t SHALL drive MODECP or MODE0 in cycle t+1.
REQ-020 DVout SHALL equal DV delayed by LAT+1 cycles, regardless of FSM state.
REQ-021 CH_EN SHALL be sampled on the first word of each event and held for the rest of that event; disabled channels get MODECP=MODE0=0 for the whole event.
REQ-022 IDLE or FLUSH with DV=1: MODECP=enabled mask; WORD_CNT=1; OVF cleared; next state ACC if EV=0, otherwise FLUSH.
REQ-023 ACC with DV=1: MODE0=enabled mask; WORD_CNT increments.
REQ-024 ACC with DV=1 and EV=1 SHALL go to FLUSH.
REQ-025 ACC with DV=0: MODECP=MODE0=0, the DSP holds, and the state is unchanged.
REQ-026 Cycles where no word is accepted SHALL drive MODECP=MODE0=0.
REQ-027 For a last word accepted at cycle t, RESULT_VALID SHALL pulse in cycle t+1+LAT for the channel mask latched for that event.
REQ-028 RESULT_VALID timing SHALL be produced by an LAT-deep shift register of masks, so back-to-back events (a new first word in the cycle after EV) yield correct, non-overlapping pulses.
REQ-029 FLUSH SHALL count LAT cycles and then go to IDLE, unless a new word has started an event; a new DV in FLUSH is accepted per REQ-022.
REQ-030 In ACC, if a word arrives with EV=0 while WORD_CNT=MAXW, the word SHALL NOT be forwarded: OVF=1, WORD_CNT holds at MAXW, next state DISCARD.
REQ-031 DISCARD SHALL keep MODECP=MODE0=0 and ignore all DV words; the DV+EV word SHALL return the FSM to IDLE with no RESULT_VALID for that event.
REQ-032 OVF SHALL stay set until the next event's first word.
REQ-033 A word that is both the MAXW-th word and carries EV=1 SHALL be accepted as a normal last word, with no overflow.
REQ-034 WORD_CNT SHALL hold its final value after the event until the next first word.
REQ-035 MAXW=1 SHALL permit single-word events only.

Reset
REQ-036 When RESET=0 at a rising edge, the next cycle SHALL have state IDLE and MODECP, MODE0, DVout, RESULT_VALID, WORD_CNT, OVF and state_out all 0.
REQ-037 Reset SHALL clear the DV delay line and the RESULT_VALID shift register, so no pulse emerges from a pre-reset event.
REQ-038 Reset asserted mid-event SHALL abort the event; the first DV after release SHALL be treated as a first word.

Verification (NCH=4, LAT=3, MAXW=8)
REQ-039 CH_EN=1111, DV for 3 cycles starting t0, EV on the 3rd -> MODECP=1111 at t0+1, MODE0=1111 at t0+2 and t0+3, RESULT_VALID=1111 at t0+6, WORD_CNT=3, states 01,01,10 then 00 after 3 cycles.
REQ-040 Single-word event (DV+EV at t0, CH_EN=0101) -> MODECP=0101 at t0+1, MODE0 never set, RESULT_VALID=0101 at t0+4, state goes to FLUSH.
REQ-041 Back-to-back events of 2 words each (CH_EN 1111 then 0011, EV at t0+1, new event at t0+2) -> RESULT_VALID 1111 at t0+5 and 0011 at t0+7, MODECP=0011 at t0+3.
REQ-042 Ten DV words without EV, then a DV+EV word -> 9th word sets OVF=1 and state 11; WORD_CNT=8; words 9-11 produce no MODE0; no RESULT_VALID; returns to IDLE.
REQ-043 8th word with EV=1 -> normal completion, OVF=0, WORD_CNT=8.
REQ-044 RESET=0 one cycle after 2nd word of an open event -> all outputs 0, no RESULT_VALID for 8 cycles, next DV gives MODECP.
